// File: rtl/dqn_fp_pkg.sv
// rtl/dqn_fp_pkg.sv - shared IEEE-754 single-precision constants and helpers for the DQN datapath
package dqn_fp_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          FP_SIGN_BIT = 31;
  localparam int          FP_MAG_MSB  = 30;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fp32_greater_than.sv
// rtl/fp32_greater_than.sv - bit-level strict a > b for IEEE-754 single, no arithmetic
module fp32_greater_than
  import dqn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        o_gt
);

  logic                a_neg;
  logic                b_neg;
  logic [FP_MAG_MSB:0] a_mag;
  logic [FP_MAG_MSB:0] b_mag;

  assign a_neg = a[FP_SIGN_BIT];
  assign b_neg = b[FP_SIGN_BIT];
  assign a_mag = a[FP_MAG_MSB:0];
  assign b_mag = b[FP_MAG_MSB:0];

  // Sign-magnitude ordering; -0 and +0 compare equal.
  always_comb begin
    o_gt = 1'b0;
    if (a_neg != b_neg) begin
      o_gt = !a_neg && !((a_mag == '0) && (b_mag == '0));
    end else if (!a_neg) begin
      o_gt = a_mag > b_mag;
    end else begin
      o_gt = a_mag < b_mag;
    end
  end

endmodule

// File: rtl/target_max_q_selector.sv
// rtl/target_max_q_selector.sv - running max Q(s',a') and argmax over a serial Q-value frame
module target_max_q_selector
  import dqn_fp_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int INDEX_WIDTH           = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_terminal,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic                   o_valid
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  generate
    if (DATA_WIDTH != 32 || NUMBER_OF_OUTPUT_NODE < 2 ||
        INDEX_WIDTH < clog2(NUMBER_OF_OUTPUT_NODE)) begin : g_bad_params
      $error("target_max_q_selector: unsupported parameter combination");
    end
  endgenerate

  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  max_q, max_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   term_q, term_d;
  logic [DATA_WIDTH-1:0]  o_data_q, o_data_d;
  logic [INDEX_WIDTH-1:0] o_index_q, o_index_d;
  logic                   o_valid_q, o_valid_d;
  logic                   gt;

  fp32_greater_than u_gt (
    .a    (i_data),
    .b    (max_q),
    .o_gt (gt)
  );

  always_comb begin
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    term_d    = term_q;
    o_data_d  = o_data_q;
    o_index_d = o_index_q;
    o_valid_d = 1'b0;
    if (i_valid) begin
      if (cnt_q == '0) begin
        max_d  = i_data;
        idx_d  = '0;
        term_d = i_terminal;
      end else if (gt) begin
        max_d = i_data;
        idx_d = cnt_q;
      end
      // Last word: publish the post-compare max directly so the result costs one clock.
      if (cnt_q == LAST_IDX) begin
        cnt_d     = '0;
        o_valid_d = 1'b1;
        o_data_d  = term_q ? DATA_WIDTH'(FP_ZERO) : max_d;
        o_index_d = term_q ? '0 : idx_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      term_q    <= 1'b0;
      o_data_q  <= '0;
      o_index_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      term_q    <= term_d;
      o_data_q  <= o_data_d;
      o_index_q <= o_index_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_index = o_index_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_target_max_q_selector.sv
// tb/tb_target_max_q_selector.sv - scoreboard bench for target_max_q_selector
module tb_target_max_q_selector;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_terminal;
  logic [31:0] o_data;
  logic [1:0]  o_index;
  logic        o_valid;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  index;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  target_max_q_selector #(
    .DATA_WIDTH            (32),
    .NUMBER_OF_OUTPUT_NODE (3),
    .INDEX_WIDTH           (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_terminal (i_terminal),
    .o_data     (o_data),
    .o_index    (o_index),
    .o_valid    (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got o_valid=1 data=%h index=%0d expected no pulse (cycle %0d)",
                   o_data, o_index, cyc);
        end else begin
          e = exp_q.pop_front();
          check("o_data", o_data, e.data);
          check("o_index", {30'd0, o_index}, {30'd0, e.index});
          check("latency_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      i_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic t, input int gap,
                           input logic last, input logic [31:0] exp_d, input logic [1:0] exp_i);
    exp_t e;
    idle(gap);
    i_valid    = 1'b1;
    i_data     = d;
    i_terminal = t;
    if (last) begin
      e.data  = exp_d;
      e.index = exp_i;
      e.due   = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid    = 1'b0;
    i_terminal = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic t0, input logic t_rest,
                            input int g0, input int g1, input int g2,
                            input logic [31:0] exp_d, input logic [1:0] exp_i);
    send_word(w0, t0, g0, 1'b0, 32'h0, 2'd0);
    send_word(w1, t_rest, g1, 1'b0, 32'h0, 2'd0);
    send_word(w2, t_rest, g2, 1'b1, exp_d, exp_i);
  endtask

  initial begin
    int budget;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    i_valid    = 1'b0;
    i_data     = 32'h0;
    i_terminal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_o_valid", {31'd0, o_valid}, 32'd0);
    check("reset_o_data", o_data, 32'h0);
    check("reset_o_index", {30'd0, o_index}, 32'd0);
    @(posedge clk);
    #1;

    send_frame(32'h3F800000, 32'h40000000, 32'h3F000000, 0, 0, 0, 0, 0, 32'h40000000, 2'd1);
    idle(2);
    send_frame(32'hBF800000, 32'hC0000000, 32'hBF000000, 0, 0, 0, 0, 0, 32'hBF000000, 2'd2);
    idle(2);
    send_frame(32'h80000000, 32'h00000000, 32'h80000000, 0, 0, 0, 0, 0, 32'h80000000, 2'd0);
    idle(1);
    send_frame(32'h3F800000, 32'h3F800000, 32'h3F000000, 0, 0, 0, 0, 0, 32'h3F800000, 2'd0);
    idle(2);
    send_frame(32'h40400000, 32'h40800000, 32'h40A00000, 1, 0, 0, 0, 0, 32'h00000000, 2'd0);
    send_frame(32'h40400000, 32'h40800000, 32'h40A00000, 0, 0, 0, 0, 0, 32'h40A00000, 2'd2);
    idle(1);
    send_frame(32'h3F800000, 32'hC0000000, 32'h7F800000, 0, 1, 0, 0, 0, 32'h7F800000, 2'd2);
    idle(3);

    send_frame(32'h3F000000, 32'h41200000, 32'hC1200000, 0, 0, 1, 3, 2, 32'h41200000, 2'd1);
    send_frame(32'hFF800000, 32'hBF800000, 32'h80000000, 0, 0, 0, 0, 0, 32'h80000000, 2'd2);
    send_frame(32'h00000000, 32'h80000000, 32'h00000000, 0, 0, 0, 2, 1, 32'h00000000, 2'd0);
    idle(3);

    send_word(32'h3F800000, 1'b0, 0, 1'b0, 32'h0, 2'd0);
    send_word(32'h40000000, 1'b0, 0, 1'b0, 32'h0, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_o_valid", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(1);
    send_frame(32'h3F000000, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 0, 32'h40000000, 2'd2);

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results expected 0", exp_q.size());
    end
    idle(4);
    @(negedge clk);
    check("hold_o_data", o_data, 32'h40000000);
    check("hold_o_index", {30'd0, o_index}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
